ws2812_tx: RTL and testbench

Serial LED driver sitting directly downstream of the per-zone colour averager. It waits for the averager to announce a finished frame, then pulls one 24-bit `{R,G,B}` zone colour at a time and shifts it onto a single WS2812B data line (GRB order, MSB first). After the last LED it holds the required latch/reset low time, then re-arms for the next frame.

---
 rtl/ws2812_tx_if.sv | 25 ++
 rtl/ws2812_tx.sv | 143 ++++++++++++++
 tb/tb_ws2812_tx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ws2812_tx_if.sv
// Frame/word handshake between the per-zone colour averager (master) and the
// WS2812B serial driver (slave).
interface ws2812_tx_if;
  logic [23:0] avg_rgb;
  logic        trig;
  logic        nxt;
  logic        t_valid;
  logic        rdy;

  modport master (
    output avg_rgb,
    output trig,
    input  nxt,
    input  t_valid,
    input  rdy
  );

  modport slave (
    input  avg_rgb,
    input  trig,
    output nxt,
    output t_valid,
    output rdy
  );
endinterface

// File: rtl/ws2812_tx.sv
// WS2812B single-wire LED driver: pulls {R,G,B} words per frame and emits GRB, MSB first.
// Optional brightness scaling of each channel at word load when WS_DIM_EN is defined.
module ws2812_tx #(
  parameter int num_leds = 26,
  parameter int t_bit    = 186,
  parameter int t0h      = 59,
  parameter int t1h      = 119,
  parameter int t_rst    = 11880,
  parameter int dim      = 128
) (
  input  logic           clk,
  input  logic           rst_n,
  ws2812_tx_if.slave     bus,
  output logic           dout
);

  localparam int TW = $clog2(t_bit);
  localparam int LW = $clog2(num_leds + 1);
  localparam int RW = $clog2(t_rst + 1);

  localparam logic [TW-1:0] BIT_LAST = TW'(t_bit - 1);
  localparam logic [TW-1:0] T0H      = TW'(t0h);
  localparam logic [TW-1:0] T1H      = TW'(t1h);
  localparam logic [LW-1:0] LED_LAST = LW'(num_leds - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(t_rst - 1);

  if (t0h < 1 || t1h <= t0h || t_bit <= t1h || num_leds < 1 || t_rst < 1 ||
      dim < 0 || dim > 255) begin : g_bad_params
    $error("ws2812_tx: inconsistent timing or dim parameters");
  end

  typedef enum logic [1:0] {LATCH, IDLE, SEND} state_t;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [4:0]    bit_idx;
  logic [LW-1:0] led_cnt;
  logic [RW-1:0] rcnt;
  logic [23:0]   sh;

  function automatic logic [7:0] scale(input logic [7:0] ch);
`ifdef WS_DIM_EN
    return 8'((16'(ch) * 16'(dim)) >> 8);
`else
    return ch;
`endif
  endfunction

  // Averager supplies {R,G,B}; the wire wants G first, then R, then B.
  function automatic logic [23:0] load_word(input logic [23:0] rgb);
    return {scale(rgb[15:8]), scale(rgb[23:16]), scale(rgb[7:0])};
  endfunction

  logic          end_bit;
  logic          last_bit;
  logic          more;
  logic          load;
  logic          shift;
  logic [TW-1:0] tnext;
  logic [TW-1:0] high_lim;

  assign end_bit  = (state == SEND) && (tcnt == BIT_LAST);
  assign last_bit = (bit_idx == 5'd23);
  assign more     = (led_cnt < LED_LAST);
  assign load     = ((state == IDLE) && bus.trig) || (end_bit && last_bit && more);
  assign shift    = end_bit && !last_bit;
  assign tnext    = tcnt + 1'b1;
  assign high_lim = sh[23] ? T1H : T0H;

  // Shift register is pure datapath: load/shift qualified by the control FSM.
  always_ff @(posedge clk) begin
    if (load)
      sh <= load_word(bus.avg_rgb);
    else if (shift)
      sh <= {sh[22:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LATCH;
      dout        <= 1'b0;
      bus.nxt     <= 1'b0;
      bus.t_valid <= 1'b0;
      bus.rdy     <= 1'b0;
      tcnt        <= '0;
      bit_idx     <= '0;
      led_cnt     <= '0;
      rcnt        <= '0;
    end else begin
      bus.nxt <= 1'b0;
      case (state)
        LATCH: begin
          if (rcnt == RST_LAST) begin
            state   <= IDLE;
            bus.rdy <= 1'b1;
            rcnt    <= '0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        IDLE: begin
          if (bus.trig) begin
            state       <= SEND;
            bus.rdy     <= 1'b0;
            bus.t_valid <= 1'b1;
            bus.nxt     <= 1'b1;
            dout        <= 1'b1;
            tcnt        <= '0;
            bit_idx     <= '0;
            led_cnt     <= '0;
          end
        end
        SEND: begin
          if (tcnt == BIT_LAST) begin
            tcnt <= '0;
            if (last_bit) begin
              if (more) begin
                bit_idx <= '0;
                led_cnt <= led_cnt + 1'b1;
                bus.nxt <= 1'b1;
                dout    <= 1'b1;
              end else begin
                state       <= LATCH;
                bus.t_valid <= 1'b0;
                dout        <= 1'b0;
                rcnt        <= '0;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              dout    <= 1'b1;
            end
          end else begin
            // Every bit opens high; it drops once the high time for its value elapses.
            tcnt <= tnext;
            dout <= (tnext < high_lim);
          end
        end
        default: state <= LATCH;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_tx.sv
// Directed bench for ws2812_tx: table of colour words per frame plus reset,
// held-trigger and mid-bit reset sequences.
module tb_ws2812_tx;

  localparam int NCAP = 320;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dout;

  int n_vec = 0;
  int n_bad = 0;

  logic cap_dout [0:NCAP];
  logic cap_nxt  [0:NCAP];
  logic cap_tv   [0:NCAP];
  logic cap_rdy  [0:NCAP];

  ws2812_tx_if bus ();

  ws2812_tx #(
    .num_leds(2),
    .t_bit   (6),
    .t0h     (2),
    .t1h     (4),
    .t_rst   (10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .dout (dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] rgb;
    logic [23:0] grb;
    bit          tog;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_rdy(input int budget);
    int i = 0;
    while (bus.rdy !== 1'b1 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("wait_rdy", 32'(bus.rdy), 32'd1);
  endtask

  // Records outputs for cycles 1..ncyc after the trigger edge; drives trig per cycle.
  task automatic capture(input int ncyc, input int tf, input int tt, input bit hold);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      cap_dout[k] = dout;
      cap_nxt[k]  = bus.nxt;
      cap_tv[k]   = bus.t_valid;
      cap_rdy[k]  = bus.rdy;
      if (hold)
        bus.trig = 1'b1;
      else
        bus.trig = (k >= tf && k < tt) ? k[0] : 1'b0;
    end
  endtask

  task automatic release_check(input string tag);
    int bad_act = 0;
    logic r [0:10];
    r[0] = bus.rdy;
    bad_act += int'(dout) + int'(bus.nxt) + int'(bus.t_valid);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      r[k] = bus.rdy;
      bad_act += int'(dout) + int'(bus.nxt) + int'(bus.t_valid);
    end
    for (int k = 0; k < 10; k++)
      check($sformatf("%s rdy low c%0d", tag, k), 32'(r[k]), 32'd0);
    check($sformatf("%s rdy rise", tag), 32'(r[10]), 32'd1);
    check($sformatf("%s no activity", tag), 32'(bad_act), 32'd0);
  endtask

  task automatic run_frame(input logic [23:0] rgb, input logic [23:0] grb, input bit tog,
                           input string tag);
    int nn = 0, tvc = 0, lat = 0, rdy_early = 0;
    wait_rdy(400);
    bus.avg_rgb = rgb;
    bus.trig    = 1'b1;
    capture(299, tog ? 40 : 0, tog ? 80 : 0, 1'b0);
    for (int led = 0; led < 2; led++) begin
      for (int b = 0; b < 24; b++) begin
        int base = 1 + (led * 24 + b) * 6;
        int hi = grb[23-b] ? 4 : 2;
        logic [5:0] got, want;
        for (int c = 0; c < 6; c++) begin
          got[c]  = cap_dout[base+c];
          want[c] = (c < hi);
        end
        check($sformatf("%s led%0d bit%0d", tag, led, b), 32'(got), 32'(want));
      end
    end
    for (int k = 1; k <= 298; k++) begin
      nn        += int'(cap_nxt[k]);
      tvc       += int'(cap_tv[k]);
      rdy_early += int'(cap_rdy[k]);
      if (k >= 289) lat += int'(cap_dout[k]);
    end
    check({tag, " nxt count"}, 32'(nn), 32'd2);
    check({tag, " nxt c1"}, 32'(cap_nxt[1]), 32'd1);
    check({tag, " nxt c145"}, 32'(cap_nxt[145]), 32'd1);
    check({tag, " t_valid len"}, 32'(tvc), 32'd288);
    check({tag, " t_valid end"}, {30'd0, cap_tv[288], cap_tv[289]}, 32'd2);
    check({tag, " latch low"}, 32'(lat), 32'd0);
    check({tag, " rdy early"}, 32'(rdy_early), 32'd0);
    check({tag, " rdy c299"}, 32'(cap_rdy[299]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef WS_DIM_EN
    vecs[0] = '{rgb: 24'hFF0000, grb: 24'h007F00, tog: 1'b0};
    vecs[1] = '{rgb: 24'h00FF00, grb: 24'h7F0000, tog: 1'b0};
    vecs[2] = '{rgb: 24'h0000FF, grb: 24'h00007F, tog: 1'b1};
    vecs[3] = '{rgb: 24'hA5C35A, grb: 24'h61522D, tog: 1'b0};
    vecs[4] = '{rgb: 24'h123456, grb: 24'h1A092B, tog: 1'b0};
    vecs[5] = '{rgb: 24'hFF8040, grb: 24'h407F20, tog: 1'b0};
`else
    vecs[0] = '{rgb: 24'hFF0000, grb: 24'h00FF00, tog: 1'b0};
    vecs[1] = '{rgb: 24'h00FF00, grb: 24'hFF0000, tog: 1'b0};
    vecs[2] = '{rgb: 24'h0000FF, grb: 24'h0000FF, tog: 1'b1};
    vecs[3] = '{rgb: 24'hA5C35A, grb: 24'hC3A55A, tog: 1'b0};
    vecs[4] = '{rgb: 24'h123456, grb: 24'h341256, tog: 1'b0};
    vecs[5] = '{rgb: 24'hFF8040, grb: 24'h80FF40, tog: 1'b0};
`endif
    bus.avg_rgb = 24'h0;
    bus.trig    = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    release_check("por");

    for (int i = 0; i < 6; i++)
      run_frame(vecs[i].rgb, vecs[i].grb, vecs[i].tog, $sformatf("v%0d", i));

    // trig held high: the next frame follows the latch without a gap cycle beyond IDLE.
    wait_rdy(400);
    bus.avg_rgb = 24'h00FF00;
    bus.trig    = 1'b1;
    capture(300, 0, 0, 1'b1);
    check("held start", 32'(cap_dout[1]), 32'd1);
    check("held gap low", 32'(cap_dout[299]), 32'd0);
    check("held rdy c299", 32'(cap_rdy[299]), 32'd1);
    check("held restart dout", 32'(cap_dout[300]), 32'd1);
    check("held restart nxt", {30'd0, cap_nxt[300], cap_rdy[300]}, 32'd2);
    bus.trig = 1'b0;
    wait_rdy(400);

    // Async reset during the high phase of LED 1, bit 5 (a 1 bit).
    bus.avg_rgb = 24'h00FF00;
    bus.trig    = 1'b1;
    capture(176, 0, 0, 1'b0);
    check("mid high before rst", 32'(cap_dout[176]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid rst dout", 32'(dout), 32'd0);
    check("mid rst flags", {29'd0, bus.nxt, bus.t_valid, bus.rdy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    release_check("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
